// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Feeds tagged commands to an external combinational 128-bit ALU and collects
// its results in command order. Commands enter through a small circular FIFO,
// are issued into a registered operand stage that drives the ALU ports, and the
// ALU outputs are captured into a result register with its own handshake.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module alu_op_sequencer #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    // command input
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_shift,
    input  logic [TAG_W-1:0] in_tag,
    // ALU drive
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shift,
    // ALU return
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    // result output
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [3:0]       LAST_OP   = 4'd5;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       shift;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    cmd_t             fifo_mem [DEPTH];
    cmd_t             in_cmd;
    cmd_t             head_cmd;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;

    // ------------------------------------------------------------------
    // Issue stage (drives the ALU) and result stage
    // ------------------------------------------------------------------
    cmd_t             iss_cmd_q, iss_cmd_d;
    logic             issue_valid_q, issue_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_illegal_q, res_illegal_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic             out_valid_q, out_valid_d;
    logic             adv1;
    logic             adv2;

    // Pack the incoming command fields into one FIFO entry.
    always_comb begin
        in_cmd        = '0;
        in_cmd.opcode = in_opcode;
        in_cmd.a      = in_a;
        in_cmd.b      = in_b;
        in_cmd.shift  = in_shift;
        in_cmd.tag    = in_tag;
    end

    // in_ready depends on the registered count only, so a full FIFO never
    // accepts even when a pop happens in the same cycle.
    assign in_ready      = (count_q < DEPTH_CNT);
    assign fifo_nonempty = (count_q != '0);
    assign push          = in_valid & in_ready;

    // Pipeline advance conditions: the result stage frees up when it is empty
    // or being consumed; the issue stage refills when empty or advancing.
    assign adv2 = issue_valid_q & (~out_valid_q | out_ready);
    assign adv1 = fifo_nonempty & (~issue_valid_q | adv2);
    assign pop  = adv1;

    assign head_cmd = fifo_mem[rd_ptr_q];

    // FIFO pointer and occupancy next-state; pointers wrap because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers, cleared by reset so buffered commands are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_cmd;
        end
    end

    // Issue stage next-state: load the FIFO head on adv1, otherwise drain on adv2.
    // The operand fields keep their last value when the stage empties.
    always_comb begin
        iss_cmd_d     = iss_cmd_q;
        issue_valid_d = issue_valid_q;
        if (adv1) begin
            iss_cmd_d     = head_cmd;
            issue_valid_d = 1'b1;
        end else if (adv2) begin
            issue_valid_d = 1'b0;
        end
    end

    // Issue stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_cmd_q     <= '0;
            issue_valid_q <= 1'b0;
        end else begin
            iss_cmd_q     <= iss_cmd_d;
            issue_valid_q <= issue_valid_d;
        end
    end

    // Result stage next-state: capture the ALU outputs on adv2, otherwise
    // drop out_valid once the consumer takes the result while data holds.
    always_comb begin
        res_data_d    = res_data_q;
        res_carry_d   = res_carry_q;
        res_illegal_d = res_illegal_q;
        res_tag_d     = res_tag_q;
        out_valid_d   = out_valid_q;
        if (adv2) begin
            res_data_d    = alu_result;
            res_carry_d   = alu_carry;
            res_illegal_d = (iss_cmd_q.opcode > LAST_OP);
            res_tag_d     = iss_cmd_q.tag;
            out_valid_d   = 1'b1;
        end else if (out_valid_q & out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    // Result stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data_q    <= '0;
            res_carry_q   <= 1'b0;
            res_illegal_q <= 1'b0;
            res_tag_q     <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            res_data_q    <= res_data_d;
            res_carry_q   <= res_carry_d;
            res_illegal_q <= res_illegal_d;
            res_tag_q     <= res_tag_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Output mapping.
    assign alu_opcode  = iss_cmd_q.opcode;
    assign alu_input1  = iss_cmd_q.a;
    assign alu_input2  = iss_cmd_q.b;
    assign alu_shift   = iss_cmd_q.shift;

    assign out_valid   = out_valid_q;
    assign out_result  = res_data_q;
    assign out_carry   = res_carry_q;
    assign out_illegal = res_illegal_q;
    assign out_tag     = res_tag_q;

    assign busy = fifo_nonempty | issue_valid_q | out_valid_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream feeder and result collector for the combinational 128-bit ALU (MAX, MIN, SLT, ROL, OR, SUB; opcodes 0-5; carry flag).
- Accepts tagged ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle into a registered operand stage that drives the ALU ports.
- Captures ALU result and carry into an output register with its own valid/ready handshake, preserving command order.

Parameters:
- WIDTH, 128, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the caller-supplied command tag.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept a command.
- in_opcode  in  4  ALU opcode.
- in_a  in  WIDTH  operand 1.
- in_b  in  WIDTH  operand 2.
- in_shift  in  5  rotate amount.
- in_tag  in  TAG_W  caller tag, returned with the result.
- alu_opcode  out  4  registered, to ALU opcode.
- alu_input1  out  WIDTH  registered, to ALU input1.
- alu_input2  out  WIDTH  registered, to ALU input2.
- alu_shift  out  5  registered, to ALU shiftValue.
- alu_result  in  WIDTH  from ALU result.
- alu_carry  in  1  from ALU carryFlag.
- out_valid  out  1  result register holds a result.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  captured result.
- out_carry  out  1  captured carry.
- out_illegal  out  1  opcode was > 5.
- out_tag  out  TAG_W  tag of the captured command.
- busy  out  1  any FIFO entry or pipeline stage occupied.

Behaviour:
- Reset: synchronous only.
  - FIFO count, pointers, issue_valid and out_valid cleared.
  - All alu_* and out_* data outputs driven to 0.
  - in_ready = 1 in the first cycle after reset; busy = 0.
- Reset mid-operation discards every buffered and in-flight command; no result emerges for it.
- Input handshake:
  - Push on in_valid & in_ready.
  - in_ready = (count < DEPTH), a pure function of registered count; no pass-through when full.
  - in_* may change freely while in_ready = 0; ignored unless pushed.
- FIFO: circular buffer, pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged. Count never exceeds DEPTH or underflows.
- Pipeline:
  - Stage 1 (issue register): opcode, operands, shift, tag, issue_valid.
  - Stage 2 (result register): result, carry, illegal, tag, out_valid.
  - adv2 = issue_valid & (~out_valid | out_ready).
  - adv1 = fifo_nonempty & (~issue_valid | adv2).
  - On adv2: the result register loads alu_result, alu_carry, (alu_opcode > 5) and the issue tag; out_valid <= 1.
  - Otherwise, if out_valid & out_ready: out_valid <= 0 and data holds.
  - On adv1: the FIFO head pops into the issue register; issue_valid <= 1.
  - Otherwise, if adv2: issue_valid <= 0.
  - alu_* outputs are stable whenever issue_valid = 1 and the stage is stalled.
  - When the issue stage empties, alu_* hold their last value (do not zero).
- Latency: a command pushed at edge k with empty pipeline appears in the issue register after edge k+1 and on out_valid after edge k+2. That gives 2 cycles minimum.
- Throughput: one result per cycle with out_ready held high.
- Order: results leave strictly in push order.
- Backpressure:
  - While out_valid & ~out_ready, out_* are held.
  - The issue register holds; the FIFO fills; in_ready drops at count = DEPTH.
  - Total capacity is DEPTH + 2 commands.
- Illegal opcode (6-15): issued normally; the captured result is whatever the ALU returns (0); out_illegal = 1; out_carry is captured as-is.
- out_carry is meaningful only for SUB; it is passed through unmodified for all opcodes.
- busy = (count != 0) | issue_valid | out_valid.

Test Plan:
- Reset then single op: push MAX a=128'h5, b=128'h9, tag=3 with out_ready=1 → out_valid rises exactly 2 cycles after the push edge with out_result=128'h9, out_tag=3, out_illegal=0; busy returns to 0 one cycle after the pop.
- Streaming: push SUB a=3,b=5; OR a=F0,b=0F; ROL a=1,shift=4 on consecutive cycles with out_ready=1 → back-to-back out_valid, results 2^128-2 (out_carry = ALU carry as sampled), 128'hFF, 128'h10, in order.
- Backpressure/full: out_ready=0, push 7 commands with DEPTH=4 → 6 accepted (tags 0-5), in_ready low from the 7th; release out_ready → tags 0-5 emerge in order with no loss or duplication; out_* stable while stalled.
- Simultaneous push/pop at count=2 → count stays 2, in_ready stays 1, wrap-around of pointers across 3 full FIFO cycles with no corruption.
- Illegal opcode 4'd9 with tag=7 → out_result=0, out_illegal=1, out_tag=7; the following legal op has out_illegal=0.
- Reset asserted with 3 queued + 2 in-flight → next cycle: out_valid=0, in_ready=1, busy=0, all out_*/alu_* = 0; no stale results afterwards.
